// File: rtl/draw_arbiter_if.sv
// Pixel-plot bus shared by the drawing clients and the arbiter.
// Parameters must match those of the draw_arbiter instance that uses it.
interface draw_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3
);
  logic [N_REQ-1:0]          req;
  logic [2*N_REQ-1:0]        shape;
  logic [X_W*N_REQ-1:0]      origin_x;
  logic [Y_W*N_REQ-1:0]      origin_y;
  logic [COLOUR_W*N_REQ-1:0] colour;
  logic [N_REQ-1:0]          grant;
  logic [N_REQ-1:0]          done;
  logic                      busy;
  logic                      plot;
  logic [X_W-1:0]            vga_x;
  logic [Y_W-1:0]            vga_y;
  logic [COLOUR_W-1:0]       vga_colour;

  modport master (
    output req, shape, origin_x, origin_y, colour,
    input  grant, done, busy, plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  req, shape, origin_x, origin_y, colour,
    output grant, done, busy, plot, vga_x, vga_y, vga_colour
  );
endinterface

// File: rtl/draw_arbiter.sv
// Round-robin owner of the VGA plot port: picks one client, rasters its
// rectangle one pixel per clock, then pulses done back to that client.
module draw_arbiter #(
  parameter int N_REQ    = 4,
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  draw_arbiter_if.slave      bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 7;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    active;
  logic                found;
  logic [CNT_W-1:0]    col;
  logic [CNT_W-1:0]    row;
  logic [CNT_W-1:0]    last_col;
  logic [CNT_W-1:0]    last_row;
  logic [X_W-1:0]      ox;
  logic [Y_W-1:0]      oy;
  logic [1:0]          sel_shape;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_colour;
  int                  idx;

  function automatic logic [CNT_W-1:0] shape_w(input logic [1:0] s);
    case (s)
      2'd0:    return CNT_W'(20);
      2'd1:    return CNT_W'(10);
      2'd2:    return CNT_W'(110);
      default: return CNT_W'(4);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] shape_h(input logic [1:0] s);
    case (s)
      2'd0:    return CNT_W'(20);
      2'd1:    return CNT_W'(10);
      2'd2:    return CNT_W'(20);
      default: return CNT_W'(4);
    endcase
  endfunction

  // Cyclic search from ptr; walking downwards lets the nearest hit win.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (bus.req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_shape  = bus.shape[2*active +: 2];
    sel_x      = bus.origin_x[active*X_W +: X_W];
    sel_y      = bus.origin_y[active*Y_W +: Y_W];
    sel_colour = bus.colour[active*COLOUR_W +: COLOUR_W];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      active         <= '0;
      col            <= '0;
      row            <= '0;
      last_col       <= '0;
      last_row       <= '0;
      ox             <= '0;
      oy             <= '0;
      bus.grant      <= '0;
      bus.done       <= '0;
      bus.busy       <= 1'b0;
      bus.plot       <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
    end else begin
      bus.done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            active    <= winner;
            ptr       <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            bus.grant <= ONE << winner;
            bus.busy  <= 1'b1;
            state     <= LOAD;
          end
        end
        // Snapshot the client's request; later input changes cannot disturb the draw.
        LOAD: begin
          ox             <= sel_x;
          oy             <= sel_y;
          col            <= '0;
          row            <= '0;
          last_col       <= shape_w(sel_shape) - 1'b1;
          last_row       <= shape_h(sel_shape) - 1'b1;
          bus.plot       <= 1'b1;
          bus.vga_x      <= sel_x;
          bus.vga_y      <= sel_y;
          bus.vga_colour <= sel_colour;
          state          <= DRAW;
        end
        DRAW: begin
          if (col == last_col && row == last_row) begin
            bus.plot  <= 1'b0;
            bus.grant <= '0;
            bus.done  <= ONE << active;
            state     <= DONE;
          end else if (col == last_col) begin
            col       <= '0;
            row       <= row + 1'b1;
            bus.vga_x <= ox;
            bus.vga_y <= oy + Y_W'(row + 1'b1);
          end else begin
            col       <= col + 1'b1;
            bus.vga_x <= ox + X_W'(col + 1'b1);
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: latency, raster order, round-robin,
// coordinate wrap, reset mid-draw and input isolation after LOAD.
module tb_draw_arbiter;
  localparam int N_REQ    = 4;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOUR_W = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  draw_arbiter_if #(.N_REQ(N_REQ), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

  draw_arbiter #(.N_REQ(N_REQ), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int client, input int sh, input int ox, input int oy, input int col);
    logic [31:0] v_sh, v_x, v_y, v_c;
    v_sh = sh; v_x = ox; v_y = oy; v_c = col;
    bus.shape[2*client +: 2]                 = v_sh[1:0];
    bus.origin_x[client*X_W +: X_W]          = v_x[X_W-1:0];
    bus.origin_y[client*Y_W +: Y_W]          = v_y[Y_W-1:0];
    bus.colour[client*COLOUR_W +: COLOUR_W]  = v_c[COLOUR_W-1:0];
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] expected, input int max_ticks, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (bus.grant == 4'b0 && waited < max_ticks);
    checkOutput(tag, bus.grant, expected);
  endtask

  function automatic int shape_w(input int sh);
    case (sh)
      0: return 20;
      1: return 10;
      2: return 110;
      default: return 4;
    endcase
  endfunction

  function automatic int shape_h(input int sh);
    case (sh)
      0: return 20;
      1: return 10;
      2: return 20;
      default: return 4;
    endcase
  endfunction

  // Called in the LOAD cycle; follows the whole draw into the following IDLE.
  task automatic check_shape(input string tag, input int client, input int sh, input int ox, input int oy,
                             input int col, input int mutate_at);
    int w, h, count, bad, side_bad, guard;
    logic [31:0] ex, ey, exp_pix, act_pix;
    w = shape_w(sh);
    h = shape_h(sh);
    count = 0; bad = 0; side_bad = 0; guard = 0;
    tick();
    while (bus.plot === 1'b1 && guard < 3000) begin
      ex = (ox + count % w) % 512;
      ey = (oy + count / w) % 256;
      exp_pix = {12'd0, col[2:0], ey[7:0], ex[8:0]};
      act_pix = {12'd0, bus.vga_colour, bus.vga_y, bus.vga_x};
      if (act_pix !== exp_pix) bad++;
      if (bus.grant !== (4'b1 << client) || bus.busy !== 1'b1 || bus.done !== 4'b0) side_bad++;
      if (count == 0 || count == w || count == w * h - 1)
        checkOutput($sformatf("%s.pix%0d", tag, count), act_pix, exp_pix);
      if (count == mutate_at) begin
        applyStimulus(client, sh, 100, 100, 2);
        bus.req[client] = 1'b0;
      end
      count++;
      guard++;
      tick();
    end
    checkOutput({tag, ".plots"}, count, w * h);
    checkOutput({tag, ".badPixels"}, bad, 0);
    checkOutput({tag, ".grantBusyDuringDraw"}, side_bad, 0);
    checkOutput({tag, ".doneCycle"}, {bus.done, bus.grant, 3'b0, bus.busy, 3'b0, bus.plot},
                {4'b1 << client, 4'b0, 3'b0, 1'b1, 3'b0, 1'b0});
    tick();
    checkOutput({tag, ".idleAfter"}, {bus.done, 3'b0, bus.busy}, 8'h00);
  endtask

  int waited;
  int done_seen;
  int order [8] = '{0, 1, 2, 3, 0, 2, 0, 2};

  initial begin
    bus.req = '0;
    bus.shape = '0;
    bus.origin_x = '0;
    bus.origin_y = '0;
    bus.colour = '0;

    // Test 1: single medium square, latency and raster order
    apply_reset();
    checkOutput("reset.outputs", {bus.grant, bus.done, 3'b0, bus.busy, 3'b0, bus.plot},
                24'h0);
    checkOutput("reset.vga", {bus.vga_colour, bus.vga_y, bus.vga_x}, 0);
    applyStimulus(0, 1, 40, 30, 4);
    bus.req = 4'b0001;
    wait_grant("t1.grant", 4'b0001, 5, waited);
    checkOutput("t1.grantLatency", waited, 1);
    check_shape("t1", 0, 1, 40, 30, 4, -1);
    bus.req = '0;

    // Test 2: round-robin with all requesting, then 0 and 2 only
    apply_reset();
    for (int c = 0; c < 4; c++) applyStimulus(c, 3, 10 * c, 5 * c, c + 1);
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_grant($sformatf("t2.grant%0d", i), 4'b1 << order[i], 10, waited);
      if (i == 4) bus.req = 4'b0101;
      check_shape($sformatf("t2.s%0d", i), order[i], 3, 10 * order[i], 5 * order[i], order[i] + 1, -1);
    end
    bus.req = '0;

    // Test 3: erase strip from client 2
    apply_reset();
    applyStimulus(2, 2, 200, 100, 6);
    bus.req = 4'b0100;
    wait_grant("t3.grant", 4'b0100, 5, waited);
    checkOutput("t3.busyAtGrant", bus.busy, 1);
    check_shape("t3", 2, 2, 200, 100, 6, -1);
    bus.req = '0;

    // Test 4: big square wrapping past x=511
    apply_reset();
    applyStimulus(3, 0, 500, 50, 1);
    bus.req = 4'b1000;
    wait_grant("t4.grant", 4'b1000, 5, waited);
    check_shape("t4", 3, 0, 500, 50, 1, -1);
    bus.req = '0;

    // Test 5: reset at plot #50 of a medium square
    apply_reset();
    applyStimulus(0, 1, 40, 30, 3);
    applyStimulus(1, 3, 0, 0, 7);
    bus.req = 4'b0001;
    wait_grant("t5.grant", 4'b0001, 5, waited);
    tick();
    for (int p = 1; p < 50; p++) tick();
    checkOutput("t5.plot50", {bus.plot, bus.vga_y, bus.vga_x}, {1'b1, 8'd34, 9'd49});
    reset = 1'b1;
    bus.req = '0;
    tick();
    checkOutput("t5.afterReset", {bus.done, bus.grant, 3'b0, bus.busy, 3'b0, bus.plot}, 24'h0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done != 4'b0) done_seen++;
    end
    checkOutput("t5.noDone", done_seen, 0);
    bus.req = 4'b0011;
    wait_grant("t5.ptrReset", 4'b0001, 5, waited);
    check_shape("t5", 0, 1, 40, 30, 3, -1);
    bus.req = '0;

    // Test 6: inputs changed and req dropped mid-draw
    apply_reset();
    applyStimulus(1, 1, 10, 20, 5);
    bus.req = 4'b0010;
    wait_grant("t6.grant", 4'b0010, 5, waited);
    check_shape("t6", 1, 1, 10, 20, 5, 30);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done != 4'b0 || bus.grant != 4'b0) done_seen++;
    end
    checkOutput("t6.singleDone", done_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
